seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked, multi-cycle successor of the 8-bit combinational ALU.
- Same base operations (forward, add, and, or) plus iterative shift/rotate ops.
- Generates ZERO and CARRY flags for every operation, not only ADD.
- Sits between the register file read ports and the writeback mux; the CPU control unit stalls on IN_READY/OUT_VALID.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SHW, $clog2(WIDTH)+1, width of the shift-amount field taken from DATA2[SHW-1:0]

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
IN_VALID  input  1  operation request valid
IN_READY  output  1  block can accept a request
SELECT  input  3  opcode
DATA1  input  WIDTH  operand 1 (shift source)
DATA2  input  WIDTH  operand 2 (shift amount in [SHW-1:0])
OUT_VALID  output  1  RESULT/flags valid
OUT_READY  input  1  consumer accepts result
RESULT  output  WIDTH  registered result
ZERO  output  1  RESULT == 0
CARRY  output  1  add carry-out / last bit shifted out

Behaviour:
- Opcodes:
  - 000 FWD: RESULT=DATA2
  - 001 ADD: DATA1+DATA2, mod 2^WIDTH; CARRY=bit WIDTH of the sum
  - 010 AND
  - 011 OR
  - 100 SLL
  - 101 SRL
  - 110 SRA: fill with DATA1 MSB
  - 111 ROR
- States:
  - IDLE: IN_READY=1, OUT_VALID=0.
  - SHIFT: iterating, IN_READY=0, OUT_VALID=0.
  - DONE: OUT_VALID=1, IN_READY=0.
- Accept occurs only when IN_VALID&&IN_READY at a rising edge. SELECT, DATA1 and the amount field are captured; later input changes are ignored.
- Ops 000-011: result and flags registered at the accept edge, IDLE->DONE. OUT_VALID is high the cycle after accept (latency 1).
- Ops 100-111, amount n = DATA2[SHW-1:0]:
  - Effective count c:
    - ROR: c = n mod WIDTH.
    - SLL/SRL/SRA: c = min(n, WIDTH).
  - c==0: RESULT=DATA1, CARRY=0, IDLE->DONE, latency 1.
  - c>0: IDLE->SHIFT. One-bit shift per cycle, internal down-counter loaded with c. After c shift cycles go to DONE. OUT_VALID rises c+1 cycles after accept.
  - CARRY = last bit shifted or rotated out.
  - SLL/SRL with c=WIDTH: RESULT=0.
  - SRA with c=WIDTH: all sign bits.
- CARRY is 0 for FWD/AND/OR. ZERO is computed from the final RESULT for every opcode.
- DONE: RESULT, ZERO and CARRY are held stable while OUT_VALID && !OUT_READY. On OUT_VALID&&OUT_READY: DONE->IDLE. No new accept in that same cycle, so minimum issue interval is 2 cycles.
- RESULT, ZERO and CARRY change only on accept edges and shift edges. They are not combinationally driven from inputs.
- Reset (RESET=0, any time, including mid-SHIFT or in DONE):
  - State=IDLE, RESULT=0, ZERO=1, CARRY=0, OUT_VALID=0, IN_READY=1, counter=0.
  - An in-flight op is discarded with no output.
  - Normal operation resumes on the first rising edge after RESET returns high.
- Undefined opcodes: none, all 8 are defined.
- X on DATA while IN_VALID=0 must not propagate into state.

Test Plan:
- Reset: hold RESET=0 mid-stream -> RESULT=0, ZERO=1, CARRY=0, OUT_VALID=0, IN_READY=1 immediately (asynchronous, no clock edge needed).
- WIDTH=8, ADD 0xFF+0x01 -> RESULT=0x00, ZERO=1, CARRY=1, OUT_VALID one cycle after accept. Then AND 0xF0&0x3C -> 0x30, ZERO=0, CARRY=0.
- SRA DATA1=0x90, DATA2=3:
  - OUT_VALID exactly 4 cycles after accept, RESULT=0xF2, CARRY=0.
  - ROR 0x81 by 9 -> c=1, RESULT=0xC0, CARRY=1, latency 2.
  - SLL 0x01 by 15 -> c=8, RESULT=0x00, ZERO=1, CARRY=1.
- Backpressure: OUT_READY=0 for 5 cycles after OUT_VALID -> RESULT/flags stable, IN_READY=0, new IN_VALID ignored. OUT_READY=1 -> IDLE next cycle, then accept.
- Reset asserted during the 3rd cycle of SRL by 6 -> no OUT_VALID. After release, FWD 0x5A completes with RESULT=0x5A.
- WIDTH=16 rerun: ADD 0xFFFF+0x0001 -> 0x0000, CARRY=1. SRL 0x8000 by 15 -> 0x0001, latency 16. SHW=5, so DATA2=0x0020 gives amount 0 and RESULT=DATA1.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU (fwd/add/and/or, iterative shifts/rotate) with ZERO/CARRY flags
//   CLK, RESET (async, active-low)
//   IN_VALID/IN_READY, SELECT[2:0], DATA1, DATA2 : request side, amount in DATA2[SHW-1:0]
//   OUT_VALID/OUT_READY, RESULT, ZERO, CARRY     : registered result side
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [SHW-1:0] W = SHW'(WIDTH);
    state_t state;
    logic [1:0] op;
    logic [SHW-1:0] cnt, n, c;
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] base, step;
    logic step_c;
    assign n = DATA2[SHW-1:0];
    assign c = SELECT[1:0] == 2'd3 ? n % W : (n > W ? W : n);
    assign sum = {1'b0, DATA1} + {1'b0, DATA2};
    assign base = SELECT[2] ? DATA1 :
                  SELECT[1:0] == 2'd0 ? DATA2 :
                  SELECT[1:0] == 2'd1 ? sum[WIDTH-1:0] :
                  SELECT[1:0] == 2'd2 ? DATA1 & DATA2 : DATA1 | DATA2;
    // one-bit step of the captured shift/rotate op applied to the running result
    assign step = op == 2'd0 ? {RESULT[WIDTH-2:0], 1'b0} :
                  op == 2'd1 ? {1'b0, RESULT[WIDTH-1:1]} :
                  op == 2'd2 ? {RESULT[WIDTH-1], RESULT[WIDTH-1:1]} :
                               {RESULT[0], RESULT[WIDTH-1:1]};
    assign step_c = op == 2'd0 ? RESULT[WIDTH-1] : RESULT[0];
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            op        <= '0;
            cnt       <= '0;
            RESULT    <= '0;
            ZERO      <= 1'b1;
            CARRY     <= 1'b0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: if (IN_VALID) begin
                    op        <= SELECT[1:0];
                    cnt       <= SELECT[2] ? c : '0;
                    RESULT    <= base;
                    ZERO      <= base == '0;
                    CARRY     <= SELECT == 3'd1 && sum[WIDTH];
                    IN_READY  <= 1'b0;
                    OUT_VALID <= !(SELECT[2] && c != '0);
                    state     <= SELECT[2] && c != '0 ? SHIFT : DONE;
                end
                SHIFT: begin
                    RESULT <= step;
                    ZERO   <= step == '0;
                    CARRY  <= step_c;
                    cnt    <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        OUT_VALID <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (OUT_READY) begin
                    OUT_VALID <= 1'b0;
                    IN_READY  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu (WIDTH 8 and 16) against an arithmetic reference model
module tb_seq_alu;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RESET;
    logic iv8, iv16, or8, or16;
    logic [2:0] sel;
    logic [15:0] d1, d2;
    logic ir8, ov8, z8, c8, ir16, ov16, z16, c16;
    logic [7:0] r8;
    logic [15:0] r16;
    logic cur16;
    logic ir, ov, z, cy;
    logic [15:0] res;
    int errors = 0, checks = 0;

    seq_alu #(.WIDTH(8)) u8 (
        .CLK(CLK), .RESET(RESET), .IN_VALID(iv8), .IN_READY(ir8), .SELECT(sel),
        .DATA1(d1[7:0]), .DATA2(d2[7:0]), .OUT_VALID(ov8), .OUT_READY(or8),
        .RESULT(r8), .ZERO(z8), .CARRY(c8)
    );
    seq_alu #(.WIDTH(16)) u16 (
        .CLK(CLK), .RESET(RESET), .IN_VALID(iv16), .IN_READY(ir16), .SELECT(sel),
        .DATA1(d1), .DATA2(d2), .OUT_VALID(ov16), .OUT_READY(or16),
        .RESULT(r16), .ZERO(z16), .CARRY(c16)
    );

    always_comb begin
        ir  = cur16 ? ir16 : ir8;
        ov  = cur16 ? ov16 : ov8;
        z   = cur16 ? z16 : z8;
        cy  = cur16 ? c16 : c8;
        res = cur16 ? r16 : {8'h00, r8};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (width %0d)", tag, got, exp, cur16 ? 16 : 8);
        end
    endtask

    task automatic set_iv(input logic v);
        if (cur16) iv16 = v; else iv8 = v;
    endtask

    task automatic set_or(input logic v);
        if (cur16) or16 = v; else or8 = v;
    endtask

    // Reference: plain arithmetic on the operands, effective count from the opcode rules
    task automatic model(input int w, input int s, input longint ai, input longint bi,
                         output longint r, output bit c_out, output int lat);
        longint mask, a, b, sa;
        int n, c;
        mask = (longint'(1) << w) - 1;
        a = ai & mask;
        b = bi & mask;
        n = int'(b & ((w == 8) ? 15 : 31));
        c = (s == 7) ? n % w : (n > w ? w : n);
        c_out = 1'b0;
        lat = 1;
        case (s)
            0: r = b;
            1: begin r = (a + b) & mask; c_out = bit'(((a + b) >> w) & 1); end
            2: r = a & b;
            3: r = a | b;
            4: begin r = (a << c) & mask; if (c > 0) c_out = bit'((a >> (w - c)) & 1); end
            5: begin r = a >> c; if (c > 0) c_out = bit'((a >> (c - 1)) & 1); end
            6: begin
                sa = ((a >> (w - 1)) & 1) != 0 ? a - (longint'(1) << w) : a;
                r = (sa >>> c) & mask;
                if (c > 0) c_out = bit'((a >> (c - 1)) & 1);
            end
            default: begin r = ((a >> c) | (a << (w - c))) & mask; if (c > 0) c_out = bit'((a >> (c - 1)) & 1); end
        endcase
        if (s >= 4) lat = c + 1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_result"}, 64'(res), 64'(0));
        chk({tag, "_zero"}, 64'(z), 64'(1));
        chk({tag, "_carry"}, 64'(cy), 64'(0));
        chk({tag, "_out_valid"}, 64'(ov), 64'(0));
        chk({tag, "_in_ready"}, 64'(ir), 64'(1));
    endtask

    task automatic txn(input int w, input int s, input longint a, input longint b, input int hold);
        longint er;
        bit ec;
        int el, lat;
        logic [17:0] held;
        cur16 = (w == 16);
        model(w, s, a, b, er, ec, el);
        @(negedge CLK);
        sel = 3'(s); d1 = 16'(a); d2 = 16'(b);
        set_iv(1'b1);
        chk("in_ready_idle", 64'(ir), 64'(1));
        @(posedge CLK); #1;
        set_iv(1'b0);
        sel = 3'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
        chk("in_ready_busy", 64'(ir), 64'(0));
        lat = 1;
        while (!ov && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("out_valid", 64'(ov), 64'(1));
        chk("latency", 64'(lat), 64'(el));
        chk("result", 64'(res), 64'(er));
        chk("zero", 64'(z), 64'(er == 0));
        chk("carry", 64'(cy), 64'(ec));
        held = {res, z, cy};
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            set_iv(1'b1);
            @(posedge CLK); #1;
            chk("hold_out_valid", 64'(ov), 64'(1));
            chk("hold_in_ready", 64'(ir), 64'(0));
            chk("hold_stable", 64'({res, z, cy}), 64'(held));
        end
        @(negedge CLK);
        set_or(1'b1);
        set_iv(1'b1);
        @(posedge CLK); #1;
        set_or(1'b0);
        set_iv(1'b0);
        chk("release_out_valid", 64'(ov), 64'(0));
        chk("release_in_ready", 64'(ir), 64'(1));
    endtask

    initial begin
        int seen;
        int w;
        RESET = 1'b1; iv8 = 1'b0; iv16 = 1'b0; or8 = 1'b0; or16 = 1'b0;
        sel = '0; d1 = '0; d2 = '0; cur16 = 1'b0;
        #2 RESET = 1'b0;
        #1 chk_reset("init8");
        cur16 = 1'b1; #1 chk_reset("init16");
        cur16 = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESET = 1'b1;

        txn(8, 1, 'hFF, 'h01, 0);
        txn(8, 2, 'hF0, 'h3C, 0);
        txn(8, 6, 'h90, 3, 0);
        txn(8, 7, 'h81, 9, 0);
        txn(8, 4, 'h01, 15, 0);
        txn(8, 3, 'hA5, 'h5A, 5);

        cur16 = 1'b0;
        @(negedge CLK);
        sel = 3'd5; d1 = 16'h00F0; d2 = 16'd6; iv8 = 1'b1;
        @(posedge CLK); #1;
        iv8 = 1'b0;
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b0;
        #1 chk_reset("midshift_reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESET = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (ov) seen++;
        end
        chk("no_out_after_reset", 64'(seen), 64'(0));
        txn(8, 0, 'h00, 'h5A, 0);

        txn(16, 1, 'hFFFF, 'h0001, 0);
        txn(16, 5, 'h8000, 15, 0);
        txn(16, 4, 'h1234, 'h0020, 0);
        txn(16, 6, 'h8001, 16, 1);
        txn(16, 7, 'h0001, 31, 0);

        for (int i = 0; i < 300; i++) begin
            w = $urandom_range(1) ? 16 : 8;
            txn(w, int'($urandom_range(7)), longint'($urandom), longint'($urandom), int'($urandom_range(2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
